// File: rtl/coarse_cfo_derotator_if.sv
// Control, symbol-in and derotated-out signals of the coarse CFO derotator.
interface coarse_cfo_derotator_if #(
   parameter int IW = 16,
   parameter int FW = 32
);
   logic                 enable;
   logic [FW-1:0]        freq_word_i;
   logic                 freq_vld_i;
   logic                 clr_i;
   logic                 vld_i;
   logic signed [IW-1:0] i_i;
   logic signed [IW-1:0] q_i;
   logic                 vld_o;
   logic signed [IW-1:0] i_o;
   logic signed [IW-1:0] q_o;
   logic                 locked_o;

   modport master (
      output enable, freq_word_i, freq_vld_i, clr_i, vld_i, i_i, q_i,
      input  vld_o, i_o, q_o, locked_o
   );
   modport slave (
      input  enable, freq_word_i, freq_vld_i, clr_i, vld_i, i_i, q_i,
      output vld_o, i_o, q_o, locked_o
   );
endinterface

// File: rtl/coarse_cfo_derotator.sv
// Latches the coarse frequency word, accumulates phase per symbol and derotates
// the symbol stream by e^{-j*phase} through a fixed 4-stage pipeline.
module coarse_cfo_derotator #(
   parameter int IW = 16,
   parameter int FW = 32,
   parameter int PW = 10,
   parameter int CW = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   coarse_cfo_derotator_if.slave bus
);
   localparam int STAGES = 4;
   localparam int PRW    = IW + CW;
   localparam int SMW    = PRW + 1;
   localparam int TN     = 2 ** PW;
   localparam logic signed [SMW-1:0] RND  = SMW'(2 ** (CW - 2));
   localparam logic signed [SMW-1:0] SMAX = SMW'(2 ** (IW - 1) - 1);
   localparam logic signed [SMW-1:0] SMIN = -SMW'(2 ** (IW - 1));

   typedef enum logic {IDLE, APPLY} state_t;

   function automatic logic signed [CW-1:0] tab_val(input int k, input logic is_sin);
      real a, v;
      a = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(TN);
      v = (is_sin ? $sin(a) : $cos(a)) * (2.0 ** (CW - 1) - 1.0);
      return (v >= 0.0) ? CW'($rtoi(v + 0.5)) : -CW'($rtoi(-v + 0.5));
   endfunction

   function automatic logic signed [IW-1:0] sat(input logic signed [SMW-1:0] v);
      if (v > SMAX) return SMAX[IW-1:0];
      if (v < SMIN) return SMIN[IW-1:0];
      return v[IW-1:0];
   endfunction

   // Elaboration-time constant tables; synthesis folds them into ROM.
   logic signed [CW-1:0] cos_tab [TN];
   logic signed [CW-1:0] sin_tab [TN];
   for (genvar k = 0; k < TN; k++) begin : g_tab
      assign cos_tab[k] = tab_val(k, 1'b0);
      assign sin_tab[k] = tab_val(k, 1'b1);
   end

   // Async assert, synchronous release of the internal reset.
   logic [1:0] rst_sync;
   logic       rst_i_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_i_n = rst_sync[1];

   state_t state_q, state_d;
   logic   accept, apply;
   assign accept = bus.vld_i & bus.enable;
   assign apply  = (state_q == APPLY);

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.clr_i)           state_d = IDLE;
      else if (bus.freq_vld_i) state_d = APPLY;
   end

   logic [FW-1:0] acc, inc;
   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         acc <= '0;
         inc <= '0;
      end else if (bus.clr_i) begin
         acc <= '0;
         inc <= '0;
      end else if (bus.freq_vld_i) begin
         // A reload in APPLY keeps the phase running; the current sample still steps by the old word.
         inc <= bus.freq_word_i;
         if (!apply)                acc <= '0;
         else if (accept)           acc <= acc + inc;
      end else if (accept && apply) begin
         acc <= acc + inc;
      end
   end

   logic [STAGES:1]       vld_pipe;
   logic [3:1]            rot;
   logic signed [IW-1:0]  i1, q1, i2, q2, i3, q3, io, qo;
   logic signed [CW-1:0]  c1, s1;
   logic signed [PRW-1:0] p_ic, p_qs, p_qc, p_is;
   logic signed [SMW-1:0] sum_i, sum_q, rnd_i, rnd_q;

   assign rnd_i = (sum_i + RND) >>> (CW - 1);
   assign rnd_q = (sum_q + RND) >>> (CW - 1);

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         vld_pipe <= '0;
         rot      <= '0;
         {i1, q1, i2, q2, i3, q3, io, qo} <= '0;
         {c1, s1}                         <= '0;
         {p_ic, p_qs, p_qc, p_is}         <= '0;
         {sum_i, sum_q}                   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], accept};
         rot      <= {rot[2:1], accept & apply};
         i1 <= bus.i_i;
         q1 <= bus.q_i;
         c1 <= cos_tab[acc[FW-1 -: PW]];
         s1 <= sin_tab[acc[FW-1 -: PW]];
         i2   <= i1;
         q2   <= q1;
         p_ic <= PRW'(i1) * PRW'(c1);
         p_qs <= PRW'(q1) * PRW'(s1);
         p_qc <= PRW'(q1) * PRW'(c1);
         p_is <= PRW'(i1) * PRW'(s1);
         i3    <= i2;
         q3    <= q2;
         sum_i <= SMW'(p_ic) + SMW'(p_qs);
         sum_q <= SMW'(p_qc) - SMW'(p_is);
         if (vld_pipe[3]) begin
            io <= rot[3] ? sat(rnd_i) : i3;
            qo <= rot[3] ? sat(rnd_q) : q3;
         end
      end
   end

   assign bus.vld_o    = vld_pipe[STAGES];
   assign bus.i_o      = io;
   assign bus.q_o      = qo;
   assign bus.locked_o = apply;
endmodule
